serdes_tx_feeder: RTL and testbench

Transmit-side byte feeder placed directly upstream of `serdes_8bit`. Buffers bytes from a producer in a small synchronous FIFO. Meters them into the serializer one at a time: `data_en` is pulsed only when `bus_free_flag` reports the link idle. Holds `data_8bit_in` stable between issues, because the serializer's input latch is level-sensitive.

---
 rtl/serdes_pkg.sv | 13 +
 rtl/serdes_sync_fifo.sv | 54 +++++
 rtl/serdes_tx_feeder.sv | 102 ++++++++++
 tb/tb_serdes_tx_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared types for the serializer transmit feeder: byte width and issue FSM states.
package serdes_pkg;

  localparam int SERDES_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_FREE
  } tx_state_e;

endpackage

// File: rtl/serdes_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head entry is readable without a pop.
module serdes_sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [W-1:0]      i_push_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [W-1:0]      o_head,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [W-1:0]    r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Flush wins over both push and pop in the same cycle.
  assign w_do_push = i_push && !o_full  && !i_flush;
  assign w_do_pop  = i_pop  && !o_empty && !i_flush;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/serdes_tx_feeder.sv
// Meters buffered bytes into serdes_8bit one at a time, waiting for the link to go busy
// and then free again between issues; flags a serializer that never goes busy.
module serdes_tx_feeder
  import serdes_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [SERDES_BYTE_W-1:0] i_wr_data,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic                     i_flush,
  input  logic                     i_bus_free_flag,
  output logic [SERDES_BYTE_W-1:0] o_data_8bit_in,
  output logic                     o_data_en,
  output logic [ADDR_W:0]          o_fifo_count,
  output logic                     o_busy_err
);

  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e                r_state;
  tx_state_e                w_state_next;
  logic [TMR_W-1:0]         r_timer;
  logic [SERDES_BYTE_W-1:0] r_data;
  logic                     r_en;
  logic                     r_err;

  logic [SERDES_BYTE_W-1:0] w_head;
  logic [ADDR_W:0]          w_count;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_issue;
  logic                     w_timeout;

  assign o_wr_ready = !w_full && !i_flush;
  assign w_push     = i_wr_valid && o_wr_ready;
  assign w_issue    = (r_state == IDLE) && !w_empty && i_bus_free_flag && !i_flush;
  assign w_timeout  = (r_timer <= TMR_W'(1));

  serdes_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (SERDES_BYTE_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data (i_wr_data),
    .i_pop       (w_issue),
    .i_flush     (i_flush),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:      if (w_issue) w_state_next = ISSUE;
      ISSUE:     w_state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!i_bus_free_flag) w_state_next = WAIT_FREE;
        else if (w_timeout)   w_state_next = IDLE;
      end
      WAIT_FREE: if (i_bus_free_flag) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_en    <= w_issue;
      // The serializer latch is level-sensitive, so the byte only moves on an issue.
      if (w_issue) r_data <= w_head;
      if (r_state == ISSUE) begin
        r_timer <= TMR_W'(BUSY_TIMEOUT);
      end else if (r_state == WAIT_BUSY && i_bus_free_flag) begin
        r_timer <= r_timer - TMR_W'(1);
      end
      if (r_state == WAIT_BUSY && i_bus_free_flag && w_timeout) r_err <= 1'b1;
    end
  end

  assign o_data_8bit_in = r_data;
  assign o_data_en      = r_en;
  assign o_fifo_count   = w_count;
  assign o_busy_err     = r_err;

endmodule

// File: tb/tb_serdes_tx_feeder.sv
// Self-checking bench: directed vector table, reset and fill/drain sequences,
// then randomized traffic against a queue-based reference model.
module tb_serdes_tx_feeder;

  localparam int DEPTH        = 8;
  localparam int ADDR_W       = 3;
  localparam int BUSY_TIMEOUT = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      wr_data = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic            flush = 1'b0;
  logic            bus_free = 1'b1;
  logic [7:0]      data_out;
  logic            data_en;
  logic [ADDR_W:0] fifo_count;
  logic            busy_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serdes_tx_feeder #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wr_data       (wr_data),
    .i_wr_valid      (wr_valid),
    .o_wr_ready      (wr_ready),
    .i_flush         (flush),
    .i_bus_free_flag (bus_free),
    .o_data_8bit_in  (data_out),
    .o_data_en       (data_en),
    .o_fifo_count    (fifo_count),
    .o_busy_err      (busy_err)
  );

  typedef struct {
    int         n;
    bit         v;
    logic [7:0] d;
    bit         f;
    bit         fl;
    bit         e_en;
    logic [7:0] e_d;
    int         e_c;
    bit         e_r;
    bit         e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, bit v, logic [7:0] d, bit f, bit fl,
                              bit e_en, logic [7:0] e_d, int e_c, bit e_r, bit e_err);
    vec_t r;
    r.n = n; r.v = v; r.d = d; r.f = f; r.fl = fl;
    r.e_en = e_en; r.e_d = e_d; r.e_c = e_c; r.e_r = e_r; r.e_err = e_err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit f, input bit fl);
    wr_valid = v;
    wr_data  = d;
    bus_free = f;
    flush    = fl;
  endtask

  task automatic do_reset();
    drive(0, 8'h00, 1, 0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reference model state for the randomized phase
  logic [7:0] q[$];
  bit         en_exp;
  logic [7:0] data_exp;
  bit         err_exp;
  int         next_allowed, lo_start, lo_end, err_at;
  bit         to_mode;

  initial begin
    int got, drop_at, cyc, issues;
    bit pend, f, v, fl, issue, push;
    logic [7:0] d;

    // Single byte, timeout, then flush during WAIT_FREE with a concurrent push.
    tbl.push_back(mk(1, 1, 8'hA5, 1, 0, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 1, 8'hA5, 0, 1, 0));
    tbl.push_back(mk(10, 0, 8'h00, 0, 0, 0, 8'hA5, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'hA5, 0, 1, 0));
    tbl.push_back(mk(5, 0, 8'h00, 1, 0, 0, 8'hA5, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'h3C, 1, 0, 0, 8'hA5, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'hA5, 1, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 1, 8'h3C, 0, 1, 0));
    tbl.push_back(mk(4, 0, 8'h00, 1, 0, 0, 8'h3C, 0, 1, 0));
    tbl.push_back(mk(3, 0, 8'h00, 1, 0, 0, 8'h3C, 0, 1, 1));
    tbl.push_back(mk(1, 1, 8'h11, 0, 0, 0, 8'h3C, 0, 1, 1));
    tbl.push_back(mk(1, 1, 8'h22, 0, 0, 0, 8'h3C, 1, 1, 1));
    tbl.push_back(mk(1, 1, 8'h33, 0, 0, 0, 8'h3C, 2, 1, 1));
    tbl.push_back(mk(1, 1, 8'h44, 0, 0, 0, 8'h3C, 3, 1, 1));
    tbl.push_back(mk(1, 1, 8'h55, 0, 0, 0, 8'h3C, 4, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h3C, 5, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 1, 8'h11, 4, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h11, 4, 1, 1));
    tbl.push_back(mk(1, 1, 8'h66, 0, 1, 0, 8'h11, 4, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h11, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h11, 0, 1, 1));
    tbl.push_back(mk(6, 0, 8'h00, 1, 0, 0, 8'h11, 0, 1, 1));

    do_reset();
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) begin
        drive(tbl[r].v, tbl[r].d, tbl[r].f, tbl[r].fl);
        #1;
        check($sformatf("vec%0d_en", r),    data_en,    tbl[r].e_en);
        check($sformatf("vec%0d_data", r),  data_out,   tbl[r].e_d);
        check($sformatf("vec%0d_count", r), fifo_count, tbl[r].e_c);
        check($sformatf("vec%0d_ready", r), wr_ready,   tbl[r].e_r);
        check($sformatf("vec%0d_err", r),   busy_err,   tbl[r].e_err);
        step();
      end
    end

    // Asynchronous reset mid-cycle with three bytes queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'hC0 + 8'(i), 0, 0);
      step();
    end
    drive(0, 8'h00, 0, 0);
    #2;
    check("pre_reset_count", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    check("rst_en", data_en, 0);
    check("rst_data", data_out, 8'h00);
    check("rst_count", fifo_count, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_err", busy_err, 0);
    step();
    step();
    rst_n = 1'b1;
    drive(0, 8'h00, 1, 0);
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (data_en) issues++;
      check("post_rst_count", fifo_count, 0);
      step();
    end
    check("post_rst_no_issue", issues, 0);

    // Fill with the bus held busy, then drain through a fast serializer.
    for (int i = 0; i < 9; i++) begin
      drive(1, 8'(i), 0, 0);
      #1;
      check("fill_count", fifo_count, (i < 8) ? i : 8);
      check("fill_ready", wr_ready, (i < 8) ? 1 : 0);
      step();
    end
    got = 0; drop_at = -1; pend = 1;
    for (cyc = 0; cyc < 300 && got < 9; cyc++) begin
      bus_free = (cyc == drop_at) ? 1'b0 : 1'b1;
      if (data_en) begin
        check("drain_byte", data_out, got);
        got++;
        drop_at = cyc + 1;
      end
      wr_valid = pend;
      wr_data  = 8'h08;
      #1;
      if (pend && wr_ready) pend = 0;
      step();
    end
    check("drain_total", got, 9);
    check("drain_empty", fifo_count, 0);

    // Randomized traffic against the reference model.
    do_reset();
    q.delete();
    en_exp = 0; data_exp = 8'h00; err_exp = 0;
    next_allowed = 0; lo_start = -1; lo_end = -1; err_at = -1; to_mode = 0;
    for (int t = 0; t < 1500; t++) begin
      if (en_exp) begin
        if ($urandom_range(0, 9) == 0) begin
          to_mode      = 1;
          next_allowed = t + BUSY_TIMEOUT + 1;
          err_at       = t + BUSY_TIMEOUT + 1;
        end else begin
          to_mode      = 0;
          lo_start     = t + int'($urandom_range(1, BUSY_TIMEOUT));
          lo_end       = lo_start + int'($urandom_range(1, 4));
          next_allowed = lo_end + 1;
        end
      end
      if (t < next_allowed) f = to_mode ? 1'b1 : !(t >= lo_start && t < lo_end);
      else                  f = ($urandom_range(0, 4) != 0);
      v  = ($urandom_range(0, 2) != 0);
      d  = 8'($urandom);
      fl = ($urandom_range(0, 39) == 0);
      drive(v, d, f, fl);
      #1;
      check("rnd_en", data_en, en_exp);
      check("rnd_data", data_out, data_exp);
      check("rnd_count", fifo_count, q.size());
      check("rnd_ready", wr_ready, (q.size() != DEPTH) && !fl);
      check("rnd_err", busy_err, err_exp);
      issue = (t >= next_allowed) && (q.size() > 0) && f && !fl;
      push  = v && (q.size() != DEPTH) && !fl;
      if (fl) begin
        q.delete();
      end else begin
        if (issue) data_exp = q.pop_front();
        if (push)  q.push_back(d);
      end
      en_exp = issue;
      if (t + 1 == err_at) err_exp = 1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
